zion_riscv_isa_lib_ex_rslt_stage: RTL and testbench

ZION_RISCV_ISA_LIB_EX_RSLT_STAGE -- requirements
Module: zion_riscv_isa_lib_ex_rslt_stage

---
 rtl/zion_riscv_isa_lib_ex_rslt_stage_pkg.sv | 19 +
 rtl/zion_riscv_isa_lib_ex_rslt_stage_if.sv | 24 ++
 rtl/zion_riscv_isa_lib_skid_fifo2.sv | 40 ++++
 rtl/zion_riscv_isa_lib_ex_rslt_stage.sv | 83 ++++++++
 tb/tb_zion_riscv_isa_lib_ex_rslt_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/zion_riscv_isa_lib_ex_rslt_stage_pkg.sv
// zion_riscv_isa_lib_ex_rslt_stage_pkg: shared entry type and width helper for the ex result stage
package zion_riscv_isa_lib_ex_rslt_stage_pkg;

    localparam int XLEN_MAX = 64;

    // Fields are sized for RV64; RV32 users fill only the low half.
    typedef struct packed {
        logic [4:0]          rd;
        logic                wb_en;
        logic [XLEN_MAX-1:0] rslt;
        logic                mem_en;
        logic [XLEN_MAX-1:0] mem_addr;
    } entry_t;

    function automatic int cpu_width(input bit rv64);
        return rv64 ? 64 : 32;
    endfunction

endpackage

// File: rtl/zion_riscv_isa_lib_ex_rslt_stage_if.sv
// zion_riscv_isa_lib_ex_rslt_stage_if: execute-side input, result-side output, redirect and bypass bundle
interface zion_riscv_isa_lib_ex_rslt_stage_if #(parameter int CPU_WIDTH = 32);
    logic                 iValid, iReady, iEpoch, iWbEn, iMemEn, flush;
    logic [4:0]           iRd;
    logic [1:0]           iBjEn;
    logic [CPU_WIDTH-1:0] iIntRslt, iBjTgt, iMemAddr;
    logic                 oValid, oReady, oWbEn, oMemEn;
    logic [4:0]           oRd;
    logic [CPU_WIDTH-1:0] oRslt, oMemAddr;
    logic                 redirEn, fwdEn;
    logic [CPU_WIDTH-1:0] redirTgt, fwdRslt;
    logic [4:0]           fwdRd;
    logic [7:0]           killCnt;

    modport master(
        output iValid, iEpoch, iRd, iWbEn, iIntRslt, iBjEn, iBjTgt, iMemEn, iMemAddr, flush, oReady,
        input  iReady, oValid, oRd, oWbEn, oRslt, oMemEn, oMemAddr, redirEn, redirTgt, fwdEn, fwdRd, fwdRslt, killCnt
    );

    modport slave(
        input  iValid, iEpoch, iRd, iWbEn, iIntRslt, iBjEn, iBjTgt, iMemEn, iMemAddr, flush, oReady,
        output iReady, oValid, oRd, oWbEn, oRslt, oMemEn, oMemAddr, redirEn, redirTgt, fwdEn, fwdRd, fwdRslt, killCnt
    );
endinterface

// File: rtl/zion_riscv_isa_lib_skid_fifo2.sv
// zion_riscv_isa_lib_skid_fifo2: two-entry in-order FIFO exposing both oldest and youngest entries
module zion_riscv_isa_lib_skid_fifo2
    import zion_riscv_isa_lib_ex_rslt_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  entry_t     din,
    output logic [1:0] count,
    output entry_t     head,
    output entry_t     tail
);
    entry_t     e0, e1;
    logic [1:0] fill;

    assign fill = count - {1'b0, pop};
    assign head = e0;
    assign tail = (count == 2'd2) ? e1 : e0;

    // occupancy: clear wins over any same-cycle push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else count <= count + {1'b0, push} - {1'b0, pop};
    end

    // storage: shift on pop from full, write into the first free slot after the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0 <= '0;
            e1 <= '0;
        end else begin
            if (pop && count == 2'd2) e0 <= e1;
            if (push && fill == 2'd0) e0 <= din;
            if (push && fill == 2'd1) e1 <= din;
        end
    end
endmodule

// File: rtl/zion_riscv_isa_lib_ex_rslt_stage.sv
// zion_riscv_isa_lib_ex_rslt_stage: buffers execute results, squashes stale-epoch work and raises fetch redirects
module zion_riscv_isa_lib_ex_rslt_stage
    import zion_riscv_isa_lib_ex_rslt_stage_pkg::*;
#(
    parameter bit RV64 = 1'b0
) (
    input logic clk,
    input logic rst,
    zion_riscv_isa_lib_ex_rslt_stage_if.slave bus
);
    localparam int CPU_WIDTH = cpu_width(RV64);

    logic [1:0]           count;
    entry_t               in_entry, head, tail;
    logic                 valid, accept, push, pop, bj, cur_epoch, redir_en, fwd_en, unused;
    logic [CPU_WIDTH-1:0] redir_tgt;
    logic [7:0]           kill_cnt;

    assign valid  = count != 2'd0;
    assign accept = bus.iValid & bus.iReady & ~bus.flush;
    assign push   = accept & (bus.iEpoch == cur_epoch);
    assign pop    = valid & bus.oReady;
    assign bj     = push & (|bus.iBjEn);
    assign fwd_en = valid & tail.wb_en;
    assign unused = ^{tail.mem_en, tail.mem_addr, tail.rslt, head.rslt, head.mem_addr};

    // pack the incoming result; writes to x0 are dropped at enqueue
    always_comb begin
        in_entry = '0;
        in_entry.rd = bus.iRd;
        in_entry.wb_en = bus.iWbEn & (bus.iRd != 5'd0);
        in_entry.rslt[CPU_WIDTH-1:0] = bus.iIntRslt;
        in_entry.mem_en = bus.iMemEn;
        in_entry.mem_addr[CPU_WIDTH-1:0] = bus.iMemAddr;
    end

    zion_riscv_isa_lib_skid_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .count (count),
        .head  (head),
        .tail  (tail)
    );

    // taken branch/jump: one-cycle redirect pulse and a new path epoch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_epoch <= 1'b0;
            redir_en  <= 1'b0;
            redir_tgt <= '0;
        end else begin
            redir_en <= bj;
            if (bj) begin
                redir_tgt <= bus.iBjTgt;
                cur_epoch <= ~cur_epoch;
            end
        end
    end

    // saturating count of instructions squashed for carrying an old epoch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) kill_cnt <= '0;
        else if (accept && bus.iEpoch != cur_epoch && kill_cnt != 8'hff) kill_cnt <= kill_cnt + 8'd1;
    end

    assign bus.iReady   = count != 2'd2;
    assign bus.oValid   = valid;
    assign bus.oRd      = valid ? head.rd : '0;
    assign bus.oWbEn    = valid & head.wb_en;
    assign bus.oRslt    = valid ? head.rslt[CPU_WIDTH-1:0] : '0;
    assign bus.oMemEn   = valid & head.mem_en;
    assign bus.oMemAddr = valid ? head.mem_addr[CPU_WIDTH-1:0] : '0;
    assign bus.redirEn  = redir_en;
    assign bus.redirTgt = redir_tgt;
    assign bus.fwdEn    = fwd_en;
    assign bus.fwdRd    = fwd_en ? tail.rd : '0;
    assign bus.fwdRslt  = fwd_en ? tail.rslt[CPU_WIDTH-1:0] : '0;
    assign bus.killCnt  = kill_cnt;
endmodule

// File: tb/tb_zion_riscv_isa_lib_ex_rslt_stage.sv
// tb_zion_riscv_isa_lib_ex_rslt_stage: directed vector table, reset corner sequence and randomized model check
module tb_zion_riscv_isa_lib_ex_rslt_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    zion_riscv_isa_lib_ex_rslt_stage_if #(.CPU_WIDTH(32)) bus();

    zion_riscv_isa_lib_ex_rslt_stage #(.RV64(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v, ep;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] rs;
        logic [1:0]  bj;
        logic [31:0] tg;
        logic        fl, rdy;
        logic        ov, ir;
        logic [4:0]  ord;
        logic        owb;
        logic [31:0] ors;
        logic        fe;
        logic [4:0]  frd;
        logic        re;
        logic [31:0] rt;
        logic [7:0]  kc;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] rslt;
        logic        mem_en;
        logic [31:0] addr;
    } m_ent_t;

    vec_t        vt[18];
    m_ent_t      mq[$];
    bit          m_epoch, m_redir;
    logic [31:0] m_tgt;
    int          m_kc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.iValid = 0; bus.iEpoch = 0; bus.iRd = 0; bus.iWbEn = 0; bus.iIntRslt = 0;
        bus.iBjEn = 0; bus.iBjTgt = 0; bus.iMemEn = 0; bus.iMemAddr = 0; bus.flush = 0; bus.oReady = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_epoch = 0; m_redir = 0; m_tgt = 0; m_kc = 0;
    endtask

    task automatic model_step();
        bit     acc, pu, stale;
        m_ent_t e;
        acc   = bus.iValid && mq.size() < 2 && !bus.flush;
        stale = acc && (bus.iEpoch != m_epoch);
        pu    = acc && !stale;
        e.rd = bus.iRd; e.wb = bus.iWbEn && bus.iRd != 0; e.rslt = bus.iIntRslt;
        e.mem_en = bus.iMemEn; e.addr = bus.iMemAddr;
        m_redir = 0;
        if (mq.size() > 0 && bus.oReady) void'(mq.pop_front());
        if (bus.flush) mq.delete();
        if (pu) begin
            mq.push_back(e);
            if (bus.iBjEn != 0) begin
                m_redir = 1; m_tgt = bus.iBjTgt; m_epoch = ~m_epoch;
            end
        end
        if (stale && m_kc < 255) m_kc++;
    endtask

    task automatic cmp_model();
        m_ent_t h, t;
        bit     ne;
        h = '{default: 0}; t = '{default: 0};
        ne = mq.size() > 0;
        if (ne) begin h = mq[0]; t = mq[$]; end
        chk("oValid", bus.oValid, ne);
        chk("iReady", bus.iReady, mq.size() < 2);
        chk("oRd", bus.oRd, h.rd);
        chk("oWbEn", bus.oWbEn, h.wb);
        chk("oRslt", bus.oRslt, h.rslt);
        chk("oMemEn", bus.oMemEn, h.mem_en);
        chk("oMemAddr", bus.oMemAddr, h.addr);
        chk("fwdEn", bus.fwdEn, t.wb);
        chk("fwdRd", bus.fwdRd, t.wb ? t.rd : 5'd0);
        chk("fwdRslt", bus.fwdRslt, t.wb ? t.rslt : 32'd0);
        chk("redirEn", bus.redirEn, m_redir);
        chk("redirTgt", bus.redirTgt, m_tgt);
        chk("killCnt", bus.killCnt, m_kc);
    endtask

    task automatic push_one(input logic ep, input logic [4:0] rd, input logic [31:0] rs,
                            input logic [1:0] bj, input logic [31:0] tg, input logic rdy);
        bus.iValid = 1; bus.iEpoch = ep; bus.iRd = rd; bus.iWbEn = 1; bus.iIntRslt = rs;
        bus.iBjEn = bj; bus.iBjTgt = tg; bus.flush = 0; bus.oReady = rdy;
        @(posedge clk); #1;
    endtask

    initial begin
        //        v ep rd wb rs      bj tg      fl rdy | ov ir ord owb ors     fe frd re rt      kc
        vt[0]  = '{1, 0, 5, 1, 'h1234, 0, 0,     0, 1,   1, 1, 5, 1, 'h1234, 1, 5, 0, 0,     0};
        vt[1]  = '{0, 0, 0, 0, 0,      0, 0,     0, 1,   0, 1, 0, 0, 0,      0, 0, 0, 0,     0};
        vt[2]  = '{1, 0, 0, 1, 'h55,   0, 0,     0, 0,   1, 1, 0, 0, 'h55,   0, 0, 0, 0,     0};
        vt[3]  = '{1, 0, 3, 1, 'h33,   0, 0,     0, 0,   1, 0, 0, 0, 'h55,   1, 3, 0, 0,     0};
        vt[4]  = '{1, 0, 7, 1, 'h77,   0, 0,     0, 0,   1, 0, 0, 0, 'h55,   1, 3, 0, 0,     0};
        vt[5]  = '{1, 0, 7, 1, 'h77,   0, 0,     0, 1,   1, 1, 3, 1, 'h33,   1, 3, 0, 0,     0};
        vt[6]  = '{1, 0, 7, 1, 'h77,   0, 0,     0, 0,   1, 0, 3, 1, 'h33,   1, 7, 0, 0,     0};
        vt[7]  = '{0, 0, 0, 0, 0,      0, 0,     0, 1,   1, 1, 7, 1, 'h77,   1, 7, 0, 0,     0};
        vt[8]  = '{0, 0, 0, 0, 0,      0, 0,     0, 1,   0, 1, 0, 0, 0,      0, 0, 0, 0,     0};
        vt[9]  = '{1, 0, 1, 1, 'h11,   1, 'h80,  0, 0,   1, 1, 1, 1, 'h11,   1, 1, 1, 'h80,  0};
        vt[10] = '{1, 0, 2, 1, 'h99,   0, 0,     0, 0,   1, 1, 1, 1, 'h11,   1, 1, 0, 'h80,  1};
        vt[11] = '{1, 1, 2, 1, 'h22,   2, 'h100, 0, 0,   1, 0, 1, 1, 'h11,   1, 2, 1, 'h100, 1};
        vt[12] = '{1, 0, 9, 1, 'h99,   1, 'h200, 1, 0,   0, 1, 0, 0, 0,      0, 0, 0, 'h100, 1};
        vt[13] = '{1, 0, 4, 1, 'h44,   0, 0,     0, 0,   1, 1, 4, 1, 'h44,   1, 4, 0, 'h100, 1};
        vt[14] = '{1, 0, 6, 1, 'h66,   1, 'h300, 1, 0,   0, 1, 0, 0, 0,      0, 0, 0, 'h100, 1};
        vt[15] = '{1, 0, 6, 1, 'h66,   0, 0,     0, 1,   1, 1, 6, 1, 'h66,   1, 6, 0, 'h100, 1};
        vt[16] = '{1, 1, 9, 1, 'h99,   0, 0,     1, 1,   0, 1, 0, 0, 0,      0, 0, 0, 'h100, 1};
        vt[17] = '{1, 1, 9, 1, 'h99,   0, 0,     0, 1,   0, 1, 0, 0, 0,      0, 0, 0, 'h100, 2};

        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_oValid", bus.oValid, 0);
        chk("rst_iReady", bus.iReady, 1);
        chk("rst_redirEn", bus.redirEn, 0);
        chk("rst_redirTgt", bus.redirTgt, 0);
        chk("rst_fwdEn", bus.fwdEn, 0);
        chk("rst_killCnt", bus.killCnt, 0);
        chk("rst_oRslt", bus.oRslt, 0);

        foreach (vt[i]) begin
            bus.iValid = vt[i].v; bus.iEpoch = vt[i].ep; bus.iRd = vt[i].rd; bus.iWbEn = vt[i].wb;
            bus.iIntRslt = vt[i].rs; bus.iBjEn = vt[i].bj; bus.iBjTgt = vt[i].tg;
            bus.iMemEn = 0; bus.iMemAddr = 0; bus.flush = vt[i].fl; bus.oReady = vt[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_oValid", i), bus.oValid, vt[i].ov);
            chk($sformatf("v%0d_iReady", i), bus.iReady, vt[i].ir);
            chk($sformatf("v%0d_oRd", i), bus.oRd, vt[i].ord);
            chk($sformatf("v%0d_oWbEn", i), bus.oWbEn, vt[i].owb);
            chk($sformatf("v%0d_oRslt", i), bus.oRslt, vt[i].ors);
            chk($sformatf("v%0d_fwdEn", i), bus.fwdEn, vt[i].fe);
            chk($sformatf("v%0d_fwdRd", i), bus.fwdRd, vt[i].frd);
            chk($sformatf("v%0d_redirEn", i), bus.redirEn, vt[i].re);
            chk($sformatf("v%0d_redirTgt", i), bus.redirTgt, vt[i].rt);
            chk($sformatf("v%0d_killCnt", i), bus.killCnt, vt[i].kc);
        end

        push_one(0, 8, 'h88, 0, 0, 0);
        push_one(0, 9, 'h99, 1, 'h400, 0);
        chk("pre_rst_full", bus.iReady, 0);
        chk("pre_rst_redir", bus.redirEn, 1);
        idle_inputs();
        #1 rst = 1;
        #1;
        chk("arst_oValid", bus.oValid, 0);
        chk("arst_iReady", bus.iReady, 1);
        chk("arst_redirEn", bus.redirEn, 0);
        chk("arst_redirTgt", bus.redirTgt, 0);
        chk("arst_fwdEn", bus.fwdEn, 0);
        chk("arst_fwdRd", bus.fwdRd, 0);
        chk("arst_oRd", bus.oRd, 0);
        chk("arst_killCnt", bus.killCnt, 0);
        @(posedge clk); #1 rst = 0;

        for (int n = 1; n <= 300; n++) begin
            push_one(1, 3, 'h5a, 0, 0, 1);
            if (n == 255 || n == 256 || n == 300) chk($sformatf("stale%0d_killCnt", n), bus.killCnt, 255);
        end
        chk("stale_oValid", bus.oValid, 0);

        idle_inputs();
        rst = 1;
        model_reset();
        @(posedge clk); #1 rst = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.iValid = $urandom_range(3) != 0;
            bus.iEpoch = ($urandom_range(7) == 0) ? ~m_epoch : m_epoch;
            bus.iRd = 5'($urandom);
            bus.iWbEn = 1'($urandom);
            bus.iIntRslt = $urandom;
            bus.iBjEn = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.iBjTgt = $urandom;
            bus.iMemEn = 1'($urandom);
            bus.iMemAddr = $urandom;
            bus.flush = $urandom_range(15) == 0;
            bus.oReady = $urandom_range(2) != 0;
            model_step();
            @(posedge clk); #1;
            cmp_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
